// File: rtl/alu_sequencer.sv
// alu_sequencer: gathers two operands from a shared bus, runs them through
// an external ALU for one cycle and registers the result and flags.
module alu_sequencer #(
    parameter int DATA_BUS_WIDTH  = 16,
    parameter int ALU_OP_NUM_BITS = 2,
    parameter int ALU_OP_ADD      = 0,
    parameter int ALU_OP_SUB      = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ALU_OP_NUM_BITS-1:0] op_in,
    input  logic                       cmp_in,
    input  logic [DATA_BUS_WIDTH-1:0]  data_in,
    input  logic                       data_in_valid,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_BUS_WIDTH-1:0]  result_out,
    output logic                       flag_z,
    output logic                       flag_c,
    output logic                       flag_n,
    output logic                       flag_v,
    output logic [DATA_BUS_WIDTH-1:0]  alu_a,
    output logic [DATA_BUS_WIDTH-1:0]  alu_b,
    output logic [ALU_OP_NUM_BITS-1:0] alu_op,
    input  logic [DATA_BUS_WIDTH-1:0]  alu_result,
    input  logic                       alu_z,
    input  logic                       alu_c,
    input  logic                       alu_n
);

    localparam int MSB = DATA_BUS_WIDTH - 1;
    localparam logic [ALU_OP_NUM_BITS-1:0] OP_ADD =
        ALU_OP_NUM_BITS'(ALU_OP_ADD);
    localparam logic [ALU_OP_NUM_BITS-1:0] OP_SUB =
        ALU_OP_NUM_BITS'(ALU_OP_SUB);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   cmp_q;
    logic   v_nxt;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: operands arrive in order, EXEC and WB last one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD_A;
            LOAD_A:  if (data_in_valid) state_nxt = LOAD_B;
            LOAD_B:  if (data_in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == WB);

    // signed overflow from operand and result sign bits
    always_comb begin
        v_nxt = 1'b0;
        if (alu_op == OP_ADD)
            v_nxt = (alu_a[MSB] == alu_b[MSB]) &&
                    (alu_result[MSB] != alu_a[MSB]);
        else if (alu_op == OP_SUB)
            v_nxt = (alu_a[MSB] != alu_b[MSB]) &&
                    (alu_result[MSB] != alu_a[MSB]);
    end

    // latch op and compare mode on an accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_op <= '0;
            cmp_q  <= 1'b0;
        end else if (state == IDLE && start) begin
            alu_op <= op_in;
            cmp_q  <= cmp_in;
        end
    end

    // operand capture from the shared bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (data_in_valid) begin
            if (state == LOAD_A) alu_a <= data_in;
            if (state == LOAD_B) alu_b <= data_in;
        end
    end

    // result and flags captured on the edge leaving EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_out <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
        end else if (state == EXEC) begin
            if (!cmp_q) result_out <= alu_result;
            flag_z <= alu_z;
            flag_c <= alu_c;
            flag_n <= alu_n;
            flag_v <= v_nxt;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed operations against an
// arithmetic reference model, with a small behavioural ALU attached.
module tb_alu_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op_in = '0;
    logic         cmp_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_in_valid = 1'b0;
    logic         busy, done;
    logic [W-1:0] result_out;
    logic         flag_z, flag_c, flag_n, flag_v;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_z, alu_c, alu_n;

    int n_checks = 0;
    int n_fail = 0;
    int cyc, done_cnt, done_at, busy_gap;

    logic [W-1:0] exp_res;
    logic         exp_z, exp_c, exp_n, exp_v;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .op_in(op_in), .cmp_in(cmp_in), .data_in(data_in),
        .data_in_valid(data_in_valid), .busy(busy), .done(done),
        .result_out(result_out), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n(flag_n), .flag_v(flag_v), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n)
    );

    always #5 clk = ~clk;

    // external ALU: add, sub (carry = no borrow), and, xor
    always_comb begin
        logic [W:0] s;
        s     = '0;
        alu_c = 1'b0;
        case (alu_op)
            2'd0: begin
                s     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = s[W];
            end
            2'd1: begin
                s     = {1'b0, alu_a - alu_b};
                alu_c = (alu_a >= alu_b);
            end
            2'd2: s = {1'b0, alu_a & alu_b};
            default: s = {1'b0, alu_a ^ alu_b};
        endcase
        alu_result = s[W-1:0];
        alu_z = (alu_result == '0);
        alu_n = alu_result[W-1];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] x);
        return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
    endfunction

    // reference: plain integer arithmetic on the operands
    task automatic model(input logic [1:0] op, input logic cmp,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int u, s;
        logic [W-1:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                u = int'(a) + int'(b);
                s = sx(a) + sx(b);
                r = u[W-1:0];
                c = (u > 65535);
                v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                u = int'(a) - int'(b);
                s = sx(a) - sx(b);
                r = u[W-1:0];
                c = (a >= b);
                v = (s > 32767) || (s < -32768);
            end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        if (!cmp) exp_res = r;
        exp_z = (r == 0);
        exp_c = c;
        exp_n = r[W-1];
        exp_v = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
        end else if (done_at < 0 && !busy) begin
            busy_gap++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic cmp,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ga, input int gb, input logic glitch,
                          input string tag);
        cyc = 0;
        done_cnt = 0;
        done_at = -1;
        busy_gap = 0;
        start = 1'b1;
        op_in = op;
        cmp_in = cmp;
        data_in_valid = 1'b1;
        data_in = W'($urandom);
        step();
        check({tag, "_busy_start"}, 32'(busy), 1);
        start = glitch;
        op_in = 2'($urandom);
        cmp_in = 1'($urandom);
        repeat (ga) begin
            data_in_valid = 1'b0;
            data_in = W'($urandom);
            step();
        end
        data_in_valid = 1'b1;
        data_in = a;
        step();
        repeat (gb) begin
            data_in_valid = 1'b0;
            data_in = W'($urandom);
            step();
        end
        data_in_valid = 1'b1;
        data_in = b;
        step();
        data_in = W'($urandom);
        for (int k = 0; k < 8 && done_at < 0; k++) step();
        start = 1'b0;
        data_in_valid = 1'b0;
        step();
        step();
        model(op, cmp, a, b);
        check({tag, "_latency"}, 32'(done_at), 32'(4 + ga + gb));
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_busy_held"}, 32'(busy_gap), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_result"}, 32'(result_out), 32'(exp_res));
        check({tag, "_flags"}, {28'd0, flag_z, flag_c, flag_n, flag_v},
              {28'd0, exp_z, exp_c, exp_n, exp_v});
        check({tag, "_ops"}, {alu_a, alu_b}, {a, b});
        check({tag, "_op"}, 32'(alu_op), 32'(op));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_result"}, 32'(result_out), 0);
        check({tag, "_flags"}, {28'd0, flag_z, flag_c, flag_n, flag_v}, 0);
        check({tag, "_ops"}, {alu_a, alu_b}, 0);
        check({tag, "_op"}, 32'(alu_op), 0);
    endtask

    initial begin
        exp_res = '0;
        #3 reset_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(2'd0, 1'b0, 16'hFFFF, 16'h0001, 0, 0, 1'b0, "add_wrap");
        run_op(2'd0, 1'b0, 16'h7FFF, 16'h0001, 0, 0, 1'b0, "add_ovf");
        run_op(2'd1, 1'b1, 16'h0005, 16'h0005, 0, 0, 1'b0, "sub_cmp");
        run_op(2'd1, 1'b0, 16'h8000, 16'h0001, 3, 3, 1'b0, "sub_gap");
        run_op(2'd0, 1'b0, 16'h1234, 16'h0101, 1, 2, 1'b1, "glitch");

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 1'($urandom),
                   W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), "rand");
        end

        // abort an operation with reset while it sits in EXEC
        done_cnt = 0;
        done_at = -1;
        start = 1'b1;
        op_in = 2'd1;
        cmp_in = 1'b0;
        step();
        start = 1'b0;
        data_in_valid = 1'b1;
        data_in = 16'h1234;
        step();
        data_in = 16'h4321;
        step();
        data_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero("abort");
        repeat (3) step();
        check("abort_no_done", 32'(done_cnt), 0);
        exp_res = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(2'd0, 1'b0, 16'h0002, 16'h0003, 0, 0, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
